// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared state type and default widths for the LDPC check-node unit.
package ldpc_pkg;
   typedef enum logic {ACCUM, EMIT} cnu_state_t;
   localparam int N_DEF = 8;
   localparam int MAG_W_DEF = N_DEF - 1;
   localparam int DMAX_DEF = 32;
   localparam int IW_DEF = $clog2(DMAX_DEF);
endpackage

// File: rtl/cnu_abs_sat.sv
// cnu_abs_sat: splits a two's complement message into sign and saturated magnitude.
module cnu_abs_sat import ldpc_pkg::*; #(
   parameter int N = N_DEF
) (
   input  logic [N-1:0] x,
   output logic         sgn,
   output logic [N-2:0] mag
);
   logic [N-1:0] neg;
   always_comb begin
      sgn = x[N-1];
      neg = -x;
      mag = !sgn ? x[N-2:0] : (x[N-2:0] == '0 ? '1 : neg[N-2:0]);
   end
endmodule

// File: rtl/cnu_minsum_serial.sv
// cnu_minsum_serial: serial min-sum check-node unit, one v2c in / one c2v out per cycle.
// Define OFFSET_MS_EN for offset min-sum (magnitudes reduced by OFFSET, clamped at 0).
module cnu_minsum_serial import ldpc_pkg::*; #(
   parameter int N = N_DEF,
   parameter int DMAX = DMAX_DEF,
   parameter int OFFSET = 1,
   localparam int IW = $clog2(DMAX)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic [IW-1:0] out_idx,
   output logic          out_last
);
   localparam int MW = N - 1;
   localparam logic [MW-1:0] MAXM = '1;
`ifdef OFFSET_MS_EN
   localparam bit OFF_EN = 1'b1;
`else
   localparam bit OFF_EN = 1'b0;
`endif
   cnu_state_t state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d, idx1_q, idx1_d;
   logic [IW:0] deg_q, deg_d;
   logic [MW-1:0] min1_q, min1_d, min2_q, min2_d, mag_in, mag_k, mag_o;
   logic [DMAX-1:0] sv_q, sv_d;
   logic par_q, par_d, sgn_in, sign_k;

   cnu_abs_sat #(.N(N)) u_abs (.x(in_data), .sgn(sgn_in), .mag(mag_in));

   always_comb begin
      in_ready = state_q == ACCUM;
      out_valid = state_q == EMIT;
      out_idx = ocnt_q;
      out_last = out_valid && ({1'b0, ocnt_q} == deg_q - 1'b1);
      mag_k = ocnt_q == idx1_q ? min2_q : min1_q;
      mag_o = !OFF_EN ? mag_k : (mag_k > MW'(OFFSET) ? mag_k - MW'(OFFSET) : '0);
      sign_k = par_q ^ sv_q[ocnt_q];
      out_data = !out_valid ? '0 : (sign_k ? -{1'b0, mag_o} : {1'b0, mag_o});
      state_d = state_q;
      cnt_d = cnt_q;
      ocnt_d = ocnt_q;
      idx1_d = idx1_q;
      deg_d = deg_q;
      min1_d = min1_q;
      min2_d = min2_q;
      sv_d = sv_q;
      par_d = par_q;
      if (in_ready && in_valid) begin
         sv_d[cnt_q] = sgn_in;
         par_d = par_q ^ sgn_in;
         if (mag_in < min1_q) begin
            min2_d = min1_q;
            min1_d = mag_in;
            idx1_d = cnt_q;
         end else if (mag_in < min2_q) begin
            min2_d = mag_in;
         end
         cnt_d = cnt_q + 1'b1;
         if (in_last || cnt_q == IW'(DMAX - 1)) begin
            state_d = EMIT;
            deg_d = {1'b0, cnt_q} + 1'b1;
            ocnt_d = '0;
         end
      end
      if (out_valid && out_ready) begin
         ocnt_d = ocnt_q + 1'b1;
         if (out_last) begin
            state_d = ACCUM;
            ocnt_d = '0;
            cnt_d = '0;
            min1_d = MAXM;
            min2_d = MAXM;
            par_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
         cnt_q <= '0;
         ocnt_q <= '0;
         idx1_q <= '0;
         deg_q <= '0;
         min1_q <= MAXM;
         min2_q <= MAXM;
         sv_q <= '0;
         par_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ocnt_q <= ocnt_d;
         idx1_q <= idx1_d;
         deg_q <= deg_d;
         min1_q <= min1_d;
         min2_q <= min2_d;
         sv_q <= sv_d;
         par_q <= par_d;
      end
   end
endmodule
